// File: rtl/ex1_stage_if.sv
// Bundle interface between the ID1 output stage and the EX1 register bank.
// The master presents decoded bundles and pipeline control; the slave returns the EX1 state.
interface ex1_stage_if #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
);
  logic            id_we;
  logic            id_valid;
  logic [XLEN-1:0] id_pc;
  logic [XLEN-1:0] id_immed;
  logic [XLEN-1:0] id_reg1;
  logic [XLEN-1:0] id_reg2;
  logic [34:0]     id_ctrl;
  logic            ex_stall;
  logic            flush;

  logic             ex1_valid;
  logic [XLEN-1:0]  ex1_pc;
  logic [XLEN-1:0]  ex1_immed;
  logic [XLEN-1:0]  ex1_reg1;
  logic [XLEN-1:0]  ex1_reg2;
  logic [34:0]      ex1_ctrl;
  logic             id_hold;
  logic [CNT_W-1:0] bubble_cnt;

  modport master (
    output id_we, id_valid, id_pc, id_immed, id_reg1, id_reg2, id_ctrl, ex_stall, flush,
    input  ex1_valid, ex1_pc, ex1_immed, ex1_reg1, ex1_reg2, ex1_ctrl, id_hold, bubble_cnt
  );

  modport slave (
    input  id_we, id_valid, id_pc, id_immed, id_reg1, id_reg2, id_ctrl, ex_stall, flush,
    output ex1_valid, ex1_pc, ex1_immed, ex1_reg1, ex1_reg2, ex1_ctrl, id_hold, bubble_cnt
  );
endinterface

// File: rtl/ex1_stage_regs.sv
// ID->EX1 pipeline register bank with load-use bubble insertion, stall/flush handling
// and a saturating bubble counter.
module ex1_stage_regs #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) (
  input  logic        CLK,
  input  logic        RST_n,
  ex1_stage_if.slave  bus_if
);
  localparam int CTRL_W = 35;

  logic              valid_q, valid_d;
  logic [XLEN-1:0]   pc_q, pc_d;
  logic [XLEN-1:0]   immed_q, immed_d;
  logic [XLEN-1:0]   reg1_q, reg1_d;
  logic [XLEN-1:0]   reg2_q, reg2_d;
  logic [CTRL_W-1:0] ctrl_q, ctrl_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic [4:0] ex1_rd;
  logic [4:0] id_rs1;
  logic [4:0] id_rs2;
  logic       hazard;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

  // A killed slot keeps its payload but can neither write the register file nor touch memory.
  function automatic logic [CTRL_W-1:0] kill_ctrl(input logic [CTRL_W-1:0] c);
    logic [CTRL_W-1:0] k;
    k        = c;
    k[13]    = 1'b0;
    k[23:20] = 4'd0;
    return k;
  endfunction

  assign ex1_rd = ctrl_q[18:14];
  assign id_rs1 = bus_if.id_ctrl[10:6];
  assign id_rs2 = bus_if.id_ctrl[5:1];

  assign hazard = valid_q & ctrl_q[23] & ctrl_q[13] & (ex1_rd != 5'd0)
                & bus_if.id_we & bus_if.id_valid
                & ((ex1_rd == id_rs1) | (ex1_rd == id_rs2));

  assign bus_if.id_hold = ~bus_if.flush & (bus_if.ex_stall | hazard);

  always_comb begin
    valid_d = valid_q;
    pc_d    = pc_q;
    immed_d = immed_q;
    reg1_d  = reg1_q;
    reg2_d  = reg2_q;
    ctrl_d  = ctrl_q;
    cnt_d   = cnt_q;
    if (bus_if.flush) begin
      valid_d = 1'b0;
      ctrl_d  = kill_ctrl(ctrl_q);
    end else if (bus_if.ex_stall) begin
      valid_d = valid_q;
    end else if (hazard) begin
      valid_d = 1'b0;
      ctrl_d  = kill_ctrl(ctrl_q);
      cnt_d   = sat_inc(cnt_q);
    end else if (bus_if.id_we) begin
      valid_d = bus_if.id_valid;
      pc_d    = bus_if.id_pc;
      immed_d = bus_if.id_immed;
      reg1_d  = bus_if.id_reg1;
      reg2_d  = bus_if.id_reg2;
      ctrl_d  = bus_if.id_ctrl;
    end else begin
      valid_d = 1'b0;
      ctrl_d  = kill_ctrl(ctrl_q);
    end
  end

  // ID -> EX1 register boundary
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      valid_q <= 1'b0;
      pc_q    <= '0;
      immed_q <= '0;
      reg1_q  <= '0;
      reg2_q  <= '0;
      ctrl_q  <= '0;
      cnt_q   <= '0;
    end else begin
      valid_q <= valid_d;
      pc_q    <= pc_d;
      immed_q <= immed_d;
      reg1_q  <= reg1_d;
      reg2_q  <= reg2_d;
      ctrl_q  <= ctrl_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus_if.ex1_valid  = valid_q;
  assign bus_if.ex1_pc     = pc_q;
  assign bus_if.ex1_immed  = immed_q;
  assign bus_if.ex1_reg1   = reg1_q;
  assign bus_if.ex1_reg2   = reg2_q;
  assign bus_if.ex1_ctrl   = ctrl_q;
  assign bus_if.bubble_cnt = cnt_q;
endmodule

// File: tb/tb_ex1_stage_regs.sv
// Bench for ex1_stage_regs: directed vector table, stall/flush/reset/saturation sequences,
// and randomized traffic against a behavioural model (second instance uses a 2-bit counter).
`timescale 1ns/1ps
module tb_ex1_stage_regs;
  logic CLK = 1'b0;
  logic RST_n = 1'b0;
  always #5 CLK = ~CLK;

  ex1_stage_if #(.XLEN(32), .CNT_W(16)) bus ();
  ex1_stage_if #(.XLEN(32), .CNT_W(2))  bus2 ();

  ex1_stage_regs #(.XLEN(32), .CNT_W(16)) dut  (.CLK(CLK), .RST_n(RST_n), .bus_if(bus.slave));
  ex1_stage_regs #(.XLEN(32), .CNT_W(2))  dut2 (.CLK(CLK), .RST_n(RST_n), .bus_if(bus2.slave));

  assign bus2.id_we    = bus.id_we;
  assign bus2.id_valid = bus.id_valid;
  assign bus2.id_pc    = bus.id_pc;
  assign bus2.id_immed = bus.id_immed;
  assign bus2.id_reg1  = bus.id_reg1;
  assign bus2.id_reg2  = bus.id_reg2;
  assign bus2.id_ctrl  = bus.id_ctrl;
  assign bus2.ex_stall = bus.ex_stall;
  assign bus2.flush    = bus.flush;

  int n_pass = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
  endtask

  // Behavioural model of the EX1 slot
  bit          m_valid;
  logic [31:0] m_pc, m_immed, m_reg1, m_reg2;
  logic [34:0] m_ctrl;
  int          m_cnt, m_cnt2;

  function automatic logic [4:0] rd_of(input logic [34:0] c);  return c[18:14]; endfunction
  function automatic logic [4:0] rs1_of(input logic [34:0] c); return c[10:6];  endfunction
  function automatic logic [4:0] rs2_of(input logic [34:0] c); return c[5:1];   endfunction
  function automatic bit is_load(input logic [34:0] c);        return c[23];    endfunction
  function automatic bit writes_rf(input logic [34:0] c);      return c[13];    endfunction

  function automatic logic [34:0] mk_ctrl(input logic [3:0] memop, input bit rw,
                                          input logic [4:0] rd, input logic [4:0] rs1,
                                          input logic [4:0] rs2);
    return {4'ha, 2'b01, 1'b1, 3'b101, 1'b0, memop, 1'b1, rd, rw, 2'b10, rs1, rs2, 1'b0};
  endfunction

  function automatic bit m_hazard();
    bit uses;
    uses = (rd_of(m_ctrl) == rs1_of(bus.id_ctrl)) || (rd_of(m_ctrl) == rs2_of(bus.id_ctrl));
    return m_valid && is_load(m_ctrl) && writes_rf(m_ctrl) && rd_of(m_ctrl) != 0
           && bus.id_we && bus.id_valid && uses;
  endfunction

  function automatic bit m_hold();
    return !bus.flush && (bus.ex_stall || m_hazard());
  endfunction

  task automatic model_reset();
    m_valid = 0; m_pc = 0; m_immed = 0; m_reg1 = 0; m_reg2 = 0; m_ctrl = 0;
    m_cnt = 0; m_cnt2 = 0;
  endtask

  task automatic model_kill();
    m_valid = 0;
    m_ctrl[13] = 1'b0;
    m_ctrl[23:20] = 4'd0;
  endtask

  task automatic model_step();
    bit haz;
    haz = m_hazard();
    if (bus.flush) model_kill();
    else if (bus.ex_stall) begin end
    else if (haz) begin
      model_kill();
      if (m_cnt < 65535) m_cnt++;
      if (m_cnt2 < 3) m_cnt2++;
    end else if (bus.id_we) begin
      m_valid = bus.id_valid;
      m_pc = bus.id_pc; m_immed = bus.id_immed;
      m_reg1 = bus.id_reg1; m_reg2 = bus.id_reg2;
      m_ctrl = bus.id_ctrl;
    end else model_kill();
  endtask

  task automatic compare_state();
    chk("ex1_valid",  64'(bus.ex1_valid),  64'(m_valid));
    chk("ex1_pc",     64'(bus.ex1_pc),     64'(m_pc));
    chk("ex1_immed",  64'(bus.ex1_immed),  64'(m_immed));
    chk("ex1_reg1",   64'(bus.ex1_reg1),   64'(m_reg1));
    chk("ex1_reg2",   64'(bus.ex1_reg2),   64'(m_reg2));
    chk("ex1_ctrl",   64'(bus.ex1_ctrl),   64'(m_ctrl));
    chk("bubble_cnt", 64'(bus.bubble_cnt), 64'(m_cnt));
    chk("valid_w2",   64'(bus2.ex1_valid), 64'(m_valid));
    chk("cnt_w2",     64'(bus2.bubble_cnt), 64'(m_cnt2));
  endtask

  task automatic set_in(input bit we, input bit vld, input logic [31:0] pc,
                        input logic [34:0] ctrl, input bit stall, input bit fl);
    bus.id_we = we; bus.id_valid = vld; bus.id_pc = pc;
    bus.id_immed = pc + 32'd1; bus.id_reg1 = ~pc; bus.id_reg2 = pc ^ 32'h55;
    bus.id_ctrl = ctrl; bus.ex_stall = stall; bus.flush = fl;
  endtask

  task automatic cycle();
    #1;
    chk("id_hold", 64'(bus.id_hold), 64'(m_hold()));
    @(posedge CLK);
    model_step();
    #1;
    compare_state();
  endtask

  typedef struct {
    bit we, vld; logic [31:0] pc; logic [3:0] memop; bit rw;
    logic [4:0] rd, rs1, rs2;
    bit e_hold, e_valid; logic [31:0] e_pc; int e_cnt;
  } vec_t;
  vec_t tbl[12];

  function automatic vec_t mkv(input bit we, input bit vld, input logic [31:0] pc,
                               input logic [3:0] memop, input bit rw, input logic [4:0] rd,
                               input logic [4:0] rs1, input logic [4:0] rs2,
                               input bit e_hold, input bit e_valid, input logic [31:0] e_pc,
                               input int e_cnt);
    vec_t v;
    v.we = we; v.vld = vld; v.pc = pc; v.memop = memop; v.rw = rw;
    v.rd = rd; v.rs1 = rs1; v.rs2 = rs2;
    v.e_hold = e_hold; v.e_valid = e_valid; v.e_pc = e_pc; v.e_cnt = e_cnt;
    return v;
  endfunction

  int sat_exp[5];

  initial begin
    //                 we vld pc       mem rw rd rs1 rs2 | hold valid pc       cnt
    tbl[0]  = mkv(1, 1, 32'h100, 4'h0, 1, 3, 0, 0,   0, 1, 32'h100, 0);
    tbl[1]  = mkv(1, 1, 32'h104, 4'h8, 1, 5, 1, 2,   0, 1, 32'h104, 0);
    tbl[2]  = mkv(1, 1, 32'h108, 4'h0, 1, 6, 0, 5,   1, 0, 32'h104, 1);
    tbl[3]  = mkv(1, 1, 32'h108, 4'h0, 1, 6, 0, 5,   0, 1, 32'h108, 1);
    tbl[4]  = mkv(1, 1, 32'h10c, 4'h8, 1, 0, 0, 0,   0, 1, 32'h10c, 1);
    tbl[5]  = mkv(1, 1, 32'h110, 4'h0, 1, 7, 0, 0,   0, 1, 32'h110, 1);
    tbl[6]  = mkv(1, 1, 32'h114, 4'h0, 1, 5, 7, 0,   0, 1, 32'h114, 1);
    tbl[7]  = mkv(1, 1, 32'h118, 4'h0, 1, 8, 5, 0,   0, 1, 32'h118, 1);
    tbl[8]  = mkv(0, 1, 32'h11c, 4'h0, 1, 8, 8, 0,   0, 0, 32'h118, 1);
    tbl[9]  = mkv(1, 0, 32'h120, 4'h8, 1, 9, 0, 0,   0, 0, 32'h120, 1);
    tbl[10] = mkv(1, 1, 32'h124, 4'h8, 1, 9, 0, 0,   0, 1, 32'h124, 1);
    tbl[11] = mkv(1, 0, 32'h128, 4'h0, 1, 1, 9, 0,   0, 0, 32'h128, 1);
    sat_exp[0] = 1; sat_exp[1] = 2; sat_exp[2] = 3; sat_exp[3] = 3; sat_exp[4] = 3;

    model_reset();
    set_in(0, 0, 32'h0, 35'd0, 0, 0);
    repeat (2) @(posedge CLK);
    #1;
    chk("rst_valid", 64'(bus.ex1_valid), 64'd0);
    chk("rst_cnt",   64'(bus.bubble_cnt), 64'd0);
    chk("rst_hold",  64'(bus.id_hold), 64'd0);
    @(negedge CLK);
    RST_n = 1'b1;

    // Directed vector table
    for (int i = 0; i < 12; i++) begin
      set_in(tbl[i].we, tbl[i].vld, tbl[i].pc,
             mk_ctrl(tbl[i].memop, tbl[i].rw, tbl[i].rd, tbl[i].rs1, tbl[i].rs2), 0, 0);
      #1;
      chk("tbl_hold", 64'(bus.id_hold), 64'(tbl[i].e_hold));
      cycle();
      chk("tbl_valid", 64'(bus.ex1_valid), 64'(tbl[i].e_valid));
      chk("tbl_pc",    64'(bus.ex1_pc), 64'(tbl[i].e_pc));
      chk("tbl_cnt",   64'(bus.bubble_cnt), 64'(tbl[i].e_cnt));
    end

    // Stall for three cycles, then flush while still stalled
    set_in(1, 1, 32'h200, mk_ctrl(4'h8, 1, 4, 0, 0), 0, 0);
    cycle();
    set_in(1, 1, 32'h204, mk_ctrl(4'h0, 1, 6, 1, 2), 1, 0);
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("stall_hold", 64'(bus.id_hold), 64'd1);
      cycle();
      chk("stall_pc",    64'(bus.ex1_pc), 64'h200);
      chk("stall_valid", 64'(bus.ex1_valid), 64'd1);
    end
    set_in(1, 1, 32'h204, mk_ctrl(4'h0, 1, 6, 1, 2), 1, 1);
    #1;
    chk("flush_hold", 64'(bus.id_hold), 64'd0);
    cycle();
    chk("flush_valid", 64'(bus.ex1_valid), 64'd0);
    chk("flush_rw",    64'(bus.ex1_ctrl[13]), 64'd0);
    chk("flush_memop", 64'(bus.ex1_ctrl[23:20]), 64'd0);
    chk("flush_pc",    64'(bus.ex1_pc), 64'h200);

    // Asynchronous reset in mid-cycle with a live instruction held in EX1
    set_in(1, 1, 32'h300, mk_ctrl(4'h8, 1, 2, 0, 0), 0, 0);
    cycle();
    #2;
    set_in(0, 0, 32'h0, 35'd0, 0, 0);
    RST_n = 1'b0;
    #1;
    model_reset();
    chk("arst_valid", 64'(bus.ex1_valid), 64'd0);
    chk("arst_pc",    64'(bus.ex1_pc), 64'd0);
    chk("arst_ctrl",  64'(bus.ex1_ctrl), 64'd0);
    chk("arst_cnt",   64'(bus.bubble_cnt), 64'd0);
    chk("arst_hold",  64'(bus.id_hold), 64'd0);
    @(negedge CLK);
    RST_n = 1'b1;

    // Five load-use pairs into the 2-bit counter instance
    for (int k = 0; k < 5; k++) begin
      set_in(1, 1, 32'h400 + 32'(k * 16), mk_ctrl(4'h8, 1, 5, 0, 0), 0, 0);
      cycle();
      set_in(1, 1, 32'h404 + 32'(k * 16), mk_ctrl(4'h0, 1, 6, 5, 0), 0, 0);
      cycle();
      chk("sat_cnt2", 64'(bus2.bubble_cnt), 64'(sat_exp[k]));
      chk("sat_cnt16", 64'(bus.bubble_cnt), 64'(k + 1));
      cycle();
      chk("sat_resume", 64'(bus.ex1_pc), 64'h404 + 64'(k * 16));
    end

    // Randomized traffic with a small register namespace to make hazards common
    for (int n = 0; n < 400; n++) begin
      logic [34:0] c;
      c = {$urandom, $urandom} & 35'h7_FFFF_FFFF;
      c[18:14] = 5'($urandom_range(0, 3));
      c[10:6]  = 5'($urandom_range(0, 3));
      c[5:1]   = 5'($urandom_range(0, 3));
      set_in(($urandom_range(0, 9) < 8), ($urandom_range(0, 9) < 9), $urandom, c,
             ($urandom_range(0, 9) < 2), ($urandom_range(0, 19) < 1));
      bus.id_immed = $urandom;
      bus.id_reg1  = $urandom;
      bus.id_reg2  = $urandom;
      cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
